// File: rtl/branch_predictor_if.sv
// Fetch-lookup, branch-resolve and statistics signals of the branch predictor.
// The master side is the pipeline (IF/ID stages); the slave side is the predictor.
interface branch_predictor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    // Fetch-stage lookup
    logic [XLEN-1:0]  if_pc;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_target;

    // Resolved branch from ID
    logic             upd_valid;
    logic [XLEN-1:0]  upd_pc;
    logic             upd_taken;
    logic [XLEN-1:0]  upd_target;
    logic             upd_pred_taken;
    logic [XLEN-1:0]  upd_pred_target;

    // Recovery and statistics
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mispred_count;

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        input  pred_taken, pred_target, mispredict, redirect_pc,
               br_count, mispred_count
    );

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        output pred_taken, pred_target, mispredict, redirect_pc,
               br_count, mispred_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational (zero latency); updates from the resolved branch in ID
// take effect at the clock edge, so a same-cycle lookup sees the old entry.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    branch_predictor_if.slave   bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;

    // Table state: valid/ctr are reset, tag/target are plain storage
    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         ctr_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];

    logic [CNT_W-1:0]   br_q;
    logic [CNT_W-1:0]   mp_q;

    // Lookup-side address split and hit
    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               lk_hit;

    // Update-side address split and hit
    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;

    assign lk_idx = bus.if_pc[IDX_W+1:2];
    assign lk_tag = bus.if_pc[XLEN-1:IDX_W+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign up_idx = bus.upd_pc[IDX_W+1:2];
    assign up_tag = bus.upd_pc[XLEN-1:IDX_W+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Prediction: valid is cleared asynchronously, so reset forces a miss here
    assign bus.pred_taken  = lk_hit && ctr_q[lk_idx][1];
    assign bus.pred_target = bus.pred_taken ? target_q[lk_idx] : bus.if_pc + XLEN'(4);

    // Misprediction: wrong direction, or right "taken" with a stale target
    assign bus.mispredict = !reset && bus.upd_valid &&
                            ((bus.upd_taken != bus.upd_pred_taken) ||
                             (bus.upd_taken && bus.upd_pred_taken &&
                              (bus.upd_target != bus.upd_pred_target)));

    assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + XLEN'(4);

    assign bus.br_count      = br_q;
    assign bus.mispred_count = mp_q;

    // Valid bits and direction counters: train on hits, allocate on taken misses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (bus.upd_valid) begin
            if (up_hit) begin
                if (bus.upd_taken) begin
                    if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
                end else begin
                    if (ctr_q[up_idx] != 2'b00) ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
                end
            end else if (bus.upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                ctr_q[up_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target storage: written on any taken update (hit retarget or allocation)
    // NOTE: tag and target arrays carry no reset; valid gates every use, and leaving
    // them out of the reset path lets them map onto plain RAM.
    always_ff @(posedge clk) begin
        if (!reset && bus.upd_valid && bus.upd_taken) begin
            target_q[up_idx] <= bus.upd_target;
            if (!up_hit) tag_q[up_idx] <= up_tag;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_q <= '0;
            mp_q <= '0;
        end else if (bus.upd_valid) begin
            if (br_q != '1) br_q <= br_q + CNT_W'(1);
            if (bus.mispredict && (mp_q != '1)) mp_q <= mp_q + CNT_W'(1);
        end
    end
endmodule
